// File: rtl/async_fifo_gray.sv
// rtl/async_fifo_gray.sv - dual-clock FIFO with Gray-coded pointer synchronisers, fill counts and status pulses
module async_fifo_gray #(
  parameter int DW          = 8,
  parameter int AW          = 6,
  parameter int SYNC_STAGES = 2,
  parameter int AF_LVL      = 60,
  parameter int AE_LVL      = 4
) (
  input  logic          clk1,
  input  logic          clk2,
  input  logic          rst,
  input  logic          wr_en,
  input  logic [DW-1:0] wr_data,
  output logic          full,
  output logic          almost_full,
  output logic [AW:0]   wr_cnt,
  output logic          overflow,
  input  logic          rd_en,
  output logic [DW-1:0] rd_data,
  output logic          rd_valid,
  output logic          empty,
  output logic          almost_empty,
  output logic [AW:0]   rd_cnt,
  output logic          underflow
);

  function automatic logic [AW:0] bin2gray(input logic [AW:0] b);
    return b ^ (b >> 1);
  endfunction

  function automatic logic [AW:0] gray2bin(input logic [AW:0] g);
    logic [AW:0] b;
    b[AW] = g[AW];
    for (int i = AW - 1; i >= 0; i--) b[i] = b[i+1] ^ g[i];
    return b;
  endfunction

  localparam logic [AW:0] AF_THR = (AW+1)'(AF_LVL);
  localparam logic [AW:0] AE_THR = (AW+1)'(AE_LVL);

  logic [DW-1:0] r_mem [0:(1<<AW)-1];

  logic [SYNC_STAGES-1:0] r_wrst_pipe, r_rrst_pipe;
  logic [AW:0] r_wsync_rgray [SYNC_STAGES];
  logic [AW:0] r_rsync_wgray [SYNC_STAGES];

  logic [AW:0]   r_wbin, r_wgray, r_wr_cnt;
  logic          r_full, r_almost_full, r_overflow;
  logic [AW:0]   r_rbin, r_rgray, r_rd_cnt;
  logic          r_empty, r_almost_empty, r_underflow, r_rd_valid;
  logic [DW-1:0] r_rd_data;

  logic          w_wrst, w_rrst, w_wr_go, w_rd_go;
  logic [AW:0]   w_wbin_next, w_wgray_next, w_rgray_s, w_wcnt_next;
  logic [AW:0]   w_rbin_next, w_rgray_next, w_wgray_s, w_rcnt_next;

  // write-domain reset: asserts immediately, releases after SYNC_STAGES clk1 edges
  always_ff @(posedge clk1 or posedge rst) begin
    if (rst) r_wrst_pipe <= '1;
    else     r_wrst_pipe <= {r_wrst_pipe[SYNC_STAGES-2:0], 1'b0};
  end

  // read-domain reset: asserts immediately, releases after SYNC_STAGES clk2 edges
  always_ff @(posedge clk2 or posedge rst) begin
    if (rst) r_rrst_pipe <= '1;
    else     r_rrst_pipe <= {r_rrst_pipe[SYNC_STAGES-2:0], 1'b0};
  end

  assign w_wrst = r_wrst_pipe[SYNC_STAGES-1];
  assign w_rrst = r_rrst_pipe[SYNC_STAGES-1];

  // bring the read Gray pointer into clk1
  always_ff @(posedge clk1 or posedge rst) begin
    if (rst || w_wrst) begin
      for (int i = 0; i < SYNC_STAGES; i++) r_wsync_rgray[i] <= '0;
    end else begin
      r_wsync_rgray[0] <= r_rgray;
      for (int i = 1; i < SYNC_STAGES; i++) r_wsync_rgray[i] <= r_wsync_rgray[i-1];
    end
  end

  // bring the write Gray pointer into clk2
  always_ff @(posedge clk2 or posedge rst) begin
    if (rst || w_rrst) begin
      for (int i = 0; i < SYNC_STAGES; i++) r_rsync_wgray[i] <= '0;
    end else begin
      r_rsync_wgray[0] <= r_wgray;
      for (int i = 1; i < SYNC_STAGES; i++) r_rsync_wgray[i] <= r_rsync_wgray[i-1];
    end
  end

  assign w_rgray_s    = r_wsync_rgray[SYNC_STAGES-1];
  assign w_wgray_s    = r_rsync_wgray[SYNC_STAGES-1];

  assign w_wr_go      = wr_en & ~r_full & ~w_wrst;
  assign w_wbin_next  = r_wbin + {{AW{1'b0}}, w_wr_go};
  assign w_wgray_next = bin2gray(w_wbin_next);
  assign w_wcnt_next  = w_wbin_next - gray2bin(w_rgray_s);

  assign w_rd_go      = rd_en & ~r_empty & ~w_rrst;
  assign w_rbin_next  = r_rbin + {{AW{1'b0}}, w_rd_go};
  assign w_rgray_next = bin2gray(w_rbin_next);
  assign w_rcnt_next  = gray2bin(w_wgray_s) - w_rbin_next;

  // storage write; contents are never reset
  always_ff @(posedge clk1) begin
    if (w_wr_go) r_mem[r_wbin[AW-1:0]] <= wr_data;
  end

  // write pointer, full/almost-full flags, fill count and overflow pulse
  always_ff @(posedge clk1 or posedge rst) begin
    if (rst || w_wrst) begin
      r_wbin        <= '0;
      r_wgray       <= '0;
      r_wr_cnt      <= '0;
      r_full        <= 1'b0;
      r_almost_full <= 1'b0;
      r_overflow    <= 1'b0;
    end else begin
      r_wbin        <= w_wbin_next;
      r_wgray       <= w_wgray_next;
      r_wr_cnt      <= w_wcnt_next;
      r_full        <= (w_wgray_next == {~w_rgray_s[AW:AW-1], w_rgray_s[AW-2:0]});
      r_almost_full <= (w_wcnt_next >= AF_THR);
      r_overflow    <= wr_en & r_full;
    end
  end

  // read pointer, registered read data, empty/almost-empty flags and underflow pulse
  always_ff @(posedge clk2 or posedge rst) begin
    if (rst || w_rrst) begin
      r_rbin         <= '0;
      r_rgray        <= '0;
      r_rd_cnt       <= '0;
      r_empty        <= 1'b1;
      r_almost_empty <= 1'b1;
      r_underflow    <= 1'b0;
      r_rd_valid     <= 1'b0;
      r_rd_data      <= '0;
    end else begin
      r_rbin         <= w_rbin_next;
      r_rgray        <= w_rgray_next;
      r_rd_cnt       <= w_rcnt_next;
      r_empty        <= (w_rgray_next == w_wgray_s);
      r_almost_empty <= (w_rcnt_next <= AE_THR);
      r_underflow    <= rd_en & r_empty;
      r_rd_valid     <= w_rd_go;
      if (w_rd_go) r_rd_data <= r_mem[r_rbin[AW-1:0]];
    end
  end

  assign full         = r_full;
  assign almost_full  = r_almost_full;
  assign wr_cnt       = r_wr_cnt;
  assign overflow     = r_overflow;
  assign rd_data      = r_rd_data;
  assign rd_valid     = r_rd_valid;
  assign empty        = r_empty;
  assign almost_empty = r_almost_empty;
  assign rd_cnt       = r_rd_cnt;
  assign underflow    = r_underflow;

endmodule
